// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icodes, register IDs, status codes and the D/E pipeline bundle.
package y86_pkg;
    localparam int DATA_W = 64;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RSP_ID   = 4'd7;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_HLT    = 3'd2;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [2:0] S_INS    = 3'd4;
    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] valc;
        logic [DATA_W-1:0] vala;
        logic [DATA_W-1:0] valb;
        logic [3:0]        dste;
        logic [3:0]        dstm;
        logic [3:0]        srca;
        logic [3:0]        srcb;
    } de_t;
    localparam de_t DE_BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0, valc: '0, vala: '0, valb: '0,
                                  dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE};
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the newest in-flight value for one source register, else the register-file read.
module fwd_select
    import y86_pkg::*;
(
    input  logic [3:0]        src,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] rval,
    output logic [DATA_W-1:0] val
);
    // RNONE short-circuits so an unused port never picks up a stage that also writes nothing
    assign val = (src == RNONE)  ? rval   :
                 (src == e_dstE) ? e_valE :
                 (src == M_dstM) ? m_valM :
                 (src == M_dstE) ? M_valE :
                 (src == W_dstM) ? W_valM :
                 (src == W_dstE) ? W_valE : rval;
endmodule

// File: rtl/decode_regread.sv
// decode_regread: Y86-64 decode/register-read stage with forwarding, load-use stall and D/E register.
module decode_regread
    import y86_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        d_stat,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [3:0]        d_rA,
    input  logic [3:0]        d_rB,
    input  logic [DATA_W-1:0] d_valC,
    input  logic [DATA_W-1:0] d_valP,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    input  logic [DATA_W-1:0] rvalA,
    input  logic [DATA_W-1:0] rvalB,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic              e_mispredict,
    input  logic              e_hold,
    output logic              d_stall,
    output logic [2:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB
);
    de_t de_q, de_d, dec;
    logic [3:0] dstE, dstM;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    assign srcA = (d_icode inside {I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ}) ? d_rA :
                  (d_icode inside {I_RET, I_POPQ}) ? RSP_ID : RNONE;
    assign srcB = (d_icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ}) ? d_rB :
                  (d_icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP_ID : RNONE;
    assign dstE = (d_icode inside {I_RRMOVQ, I_IRMOVQ, I_OPQ}) ? d_rB :
                  (d_icode inside {I_CALL, I_RET, I_PUSHQ, I_POPQ}) ? RSP_ID : RNONE;
    assign dstM = (d_icode inside {I_MRMOVQ, I_POPQ}) ? d_rA : RNONE;
    fwd_select u_fwd_a (
        .src(srcA), .e_dstE(e_dstE), .M_dstM(M_dstM), .M_dstE(M_dstE), .W_dstM(W_dstM), .W_dstE(W_dstE),
        .e_valE(e_valE), .m_valM(m_valM), .M_valE(M_valE), .W_valM(W_valM), .W_valE(W_valE),
        .rval(rvalA), .val(fwd_a)
    );
    fwd_select u_fwd_b (
        .src(srcB), .e_dstE(e_dstE), .M_dstM(M_dstM), .M_dstE(M_dstE), .W_dstM(W_dstM), .W_dstE(W_dstE),
        .e_valE(e_valE), .m_valM(m_valM), .M_valE(M_valE), .W_valM(W_valM), .W_valE(W_valE),
        .rval(rvalB), .val(fwd_b)
    );
    // a load in E whose destination is read here cannot be forwarded yet
    assign d_stall = (de_q.icode inside {I_MRMOVQ, I_POPQ}) && (de_q.dstm != RNONE) &&
                     (de_q.dstm == srcA || de_q.dstm == srcB);
    always_comb begin
        dec       = DE_BUBBLE;
        dec.stat  = d_stat;
        dec.icode = d_icode;
        dec.ifun  = d_ifun;
        dec.valc  = d_valC;
        dec.vala  = (d_icode == I_JXX || d_icode == I_CALL) ? d_valP : fwd_a;
        dec.valb  = fwd_b;
        dec.dste  = dstE;
        dec.dstm  = dstM;
        dec.srca  = srcA;
        dec.srcb  = srcB;
    end
    assign de_d = e_hold ? de_q : (e_mispredict || d_stall) ? DE_BUBBLE : dec;
    always_ff @(posedge clk) de_q <= rst ? DE_BUBBLE : de_d;
    assign E_stat  = de_q.stat;
    assign E_icode = de_q.icode;
    assign E_ifun  = de_q.ifun;
    assign E_valC  = de_q.valc;
    assign E_valA  = de_q.vala;
    assign E_valB  = de_q.valb;
    assign E_dstE  = de_q.dste;
    assign E_dstM  = de_q.dstm;
    assign E_srcA  = de_q.srca;
    assign E_srcB  = de_q.srcb;
endmodule
